input_debouncer: RTL and testbench

Conditions the asynchronous board inputs (push-button and slide switches) before they reach the sigma SoC's irq_btn_i and gpio_bi.
- Each channel gets a 2-flop synchroniser and a per-channel debounce counter.
- Each channel produces a stable level plus one-cycle rise/fall pulses.
- Instantiated in the board top between the pad inputs and sigma, clocked by the PLL output clock.

---
 rtl/input_debouncer.sv | 82 ++++++++
 tb/tb_input_debouncer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Board-input conditioner: per-channel 2-flop synchroniser, consecutive-cycle
// debounce counter, debounced level plus one-cycle rise/fall pulses.
module input_debouncer #(
  parameter int                NUM_CH          = 17,
  parameter int                DEBOUNCE_CYCLES = 1000000,
  parameter int                CNT_WIDTH       = 20,
  parameter logic [NUM_CH-1:0] RST_VAL         = '0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [NUM_CH-1:0] raw_i,
  output logic [NUM_CH-1:0] db_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic              any_rise_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0]    sync_p0;
  logic [NUM_CH-1:0]    sync_p1;
  logic [CNT_WIDTH-1:0] cnt_p2 [NUM_CH];

  logic [CNT_WIDTH-1:0] cnt_d  [NUM_CH];
  logic [NUM_CH-1:0]    db_d;
  logic [NUM_CH-1:0]    rise_d;
  logic [NUM_CH-1:0]    fall_d;

  // Counter clears on acceptance, so it never reaches a wrap point.
  function automatic logic [CNT_WIDTH-1:0] cnt_step(input logic [CNT_WIDTH-1:0] cnt);
    return cnt + CNT_WIDTH'(1);
  endfunction

  // Stage p0/p1: two-flop synchroniser on the asynchronous pads
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= raw_i;
      sync_p1 <= sync_p0;
    end
  end

  // A channel is pending while its synchronised value disagrees with db_o;
  // returning to agreement before the count completes discards the count.
  always_comb begin
    db_d   = db_o;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      if (sync_p1[i] != db_o[i]) begin
        if (cnt_p2[i] == CNT_LAST) begin
          db_d[i]   = sync_p1[i];
          rise_d[i] = sync_p1[i];
          fall_d[i] = ~sync_p1[i];
        end else begin
          cnt_d[i] = cnt_step(cnt_p2[i]);
        end
      end
    end
  end

  // Stage p2: counters, debounced level and edge pulses
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < NUM_CH; i++) cnt_p2[i] <= '0;
      db_o       <= RST_VAL;
      rise_o     <= '0;
      fall_o     <= '0;
      any_rise_o <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt_p2[i] <= cnt_d[i];
      db_o       <= db_d;
      rise_o     <= rise_d;
      fall_o     <= fall_d;
      any_rise_o <= |rise_d;
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with DEBOUNCE_CYCLES=4: reset, clean
// press/release, glitch rejection, bounce, parallel channels, mid-count reset.
module tb_input_debouncer;

  localparam int NUM_CH = 17;

  logic              clk = 1'b0;
  logic              arst;
  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] db, rise, fall;
  logic              any_rise;

  int checks = 0;
  int errors = 0;

  input_debouncer #(
    .NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(20), .RST_VAL('0)
  ) dut (
    .clk_i(clk), .arst_i(arst), .raw_i(raw),
    .db_o(db), .rise_o(rise), .fall_o(fall), .any_rise_o(any_rise)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [NUM_CH-1:0] acc_db, acc_rise, acc_fall;
  int                n_pulse, pulse_at;

  initial begin
    arst = 1'b1;
    raw  = '1;
    // Reset held with all inputs high
    tick(1);
    chk("rst_db", 32'(db), 32'h0);
    chk("rst_rise", 32'(rise), 32'h0);
    tick(1);
    chk("rst_fall", 32'(fall), 32'h0);
    chk("rst_any", 32'(any_rise), 32'h0);

    // Release: first sampling edge E0 is the next posedge
    arst = 1'b0;
    tick(5);
    chk("rel_e4_db", 32'(db), 32'h0);
    tick(1);
    chk("rel_e5_db", 32'(db), 32'h1FFFF);
    chk("rel_e5_rise", 32'(rise), 32'h1FFFF);
    chk("rel_e5_any", 32'(any_rise), 32'h1);
    chk("rel_e5_fall", 32'(fall), 32'h0);
    tick(1);
    chk("rel_e6_rise", 32'(rise), 32'h0);
    chk("rel_e6_any", 32'(any_rise), 32'h0);

    // All channels fall
    raw = '0;
    tick(5);
    chk("allfall_e4_db", 32'(db), 32'h1FFFF);
    tick(1);
    chk("allfall_e5_db", 32'(db), 32'h0);
    chk("allfall_e5_fall", 32'(fall), 32'h1FFFF);
    chk("allfall_e5_rise", 32'(rise), 32'h0);
    tick(1);
    chk("allfall_e6_fall", 32'(fall), 32'h0);

    // Clean press on channel 0
    raw = 17'h00001;
    tick(5);
    chk("press_e4_db", 32'(db), 32'h0);
    tick(1);
    chk("press_e5_db", 32'(db), 32'h00001);
    chk("press_e5_rise", 32'(rise), 32'h00001);
    chk("press_e5_fall", 32'(fall), 32'h0);
    tick(1);
    chk("press_e6_rise", 32'(rise), 32'h0);

    // Clean release on channel 0
    raw = 17'h00000;
    tick(5);
    chk("relz_e4_db", 32'(db), 32'h00001);
    tick(1);
    chk("relz_e5_db", 32'(db), 32'h0);
    chk("relz_e5_fall", 32'(fall), 32'h00001);
    chk("relz_e5_any", 32'(any_rise), 32'h0);
    tick(1);
    chk("relz_e6_fall", 32'(fall), 32'h0);

    // Glitch: channel 3 differs at s for 3 cycles only
    raw = 17'h00008;
    acc_db = '0; acc_rise = '0; acc_fall = '0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      acc_db |= db; acc_rise |= rise; acc_fall |= fall;
    end
    raw = 17'h00000;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      acc_db |= db; acc_rise |= rise; acc_fall |= fall;
    end
    chk("glitch3_db", 32'(acc_db), 32'h0);
    chk("glitch3_rise", 32'(acc_rise), 32'h0);
    chk("glitch3_fall", 32'(acc_fall), 32'h0);

    // Same channel held 4 cycles at s: accepted, then falls back
    raw = 17'h00008;
    tick(4);
    raw = 17'h00000;
    tick(1);
    chk("hold4_e4_db", 32'(db), 32'h0);
    tick(1);
    chk("hold4_e5_db", 32'(db), 32'h00008);
    chk("hold4_e5_rise", 32'(rise), 32'h00008);
    tick(3);
    chk("hold4_e8_db", 32'(db), 32'h00008);
    tick(1);
    chk("hold4_e9_db", 32'(db), 32'h0);
    chk("hold4_e9_fall", 32'(fall), 32'h00008);

    // Bounce 1,0,1,0,1 then hold 1: one rise, 5 edges after the last drive
    n_pulse = 0;
    pulse_at = -1;
    for (int i = 0; i < 4; i++) begin
      raw[0] = (i % 2 == 0);
      tick(1);
      if (rise[0]) n_pulse++;
    end
    raw[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (rise[0]) begin
        n_pulse++;
        pulse_at = i;
      end
    end
    chk("bounce_npulse", 32'(n_pulse), 32'd1);
    chk("bounce_pulse_at", 32'(pulse_at), 32'd6);
    chk("bounce_db", 32'(db), 32'h00001);

    // Prime channel 5 high, then 1 and 16 rise while 5 falls
    raw = 17'h00021;
    tick(8);
    chk("prime_db", 32'(db), 32'h00021);
    raw = 17'h10003;
    tick(5);
    chk("indep_e4_rise", 32'(rise), 32'h0);
    tick(1);
    chk("indep_e5_rise", 32'(rise), 32'h10002);
    chk("indep_e5_fall", 32'(fall), 32'h00020);
    chk("indep_e5_any", 32'(any_rise), 32'h1);
    chk("indep_e5_db", 32'(db), 32'h10003);
    tick(1);
    chk("indep_e6_rise", 32'(rise), 32'h0);
    chk("indep_e6_fall", 32'(fall), 32'h0);

    // Reset partway through channel 2's count
    raw = 17'h10007;
    tick(3);
    arst = 1'b1;
    #1;
    chk("midrst_db", 32'(db), 32'h0);
    chk("midrst_rise", 32'(rise), 32'h0);
    chk("midrst_fall", 32'(fall), 32'h0);
    tick(2);
    arst = 1'b0;
    tick(5);
    chk("midrst_e4_db", 32'(db), 32'h0);
    chk("midrst_e4_rise", 32'(rise), 32'h0);
    tick(1);
    chk("midrst_e5_db", 32'(db), 32'h10007);
    chk("midrst_e5_rise", 32'(rise), 32'h10007);
    chk("midrst_e5_any", 32'(any_rise), 32'h1);
    tick(1);
    chk("midrst_e6_rise", 32'(rise), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
